// File: rtl/ee354_project_pkg.sv
// Shared definitions for the snake direction-input block: direction codes,
// turn FSM states and the opposite-direction helper.
package ee354_project_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic {
        ST_READY  = 1'b0,
        ST_LOCKED = 1'b1
    } turn_state_t;

    // Up/down and left/right share bit 1 and differ in bit 0.
    function automatic logic [1:0] opposite_dir(input logic [1:0] dir);
        return {dir[1], ~dir[0]};
    endfunction

endpackage

// File: rtl/ee354_project_debounce.sv
// One push-button channel: 2-flop synchroniser, debounce counter and a
// one-cycle press event on each debounced 0->1 transition.
module ee354_project_debounce
    import ee354_project_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic press
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          level_dly_q;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count while the synced input disagrees with the debounced level; flip on terminal count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_q & ~level_dly_q;
    end

    // Synchroniser, debounce state and registered press event.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            cnt_q       <= '0;
            press_q     <= 1'b0;
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            cnt_q       <= cnt_d;
            press_q     <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/ee354_project_input.sv
// Snake direction input: four debounced buttons -> arbitrated, reverse-filtered
// direction command (In_Dirn + SCEN) with one accepted turn per Speed_Clk tick.
// Optional macro EE354_TURN_BUFFER_EN adds a 1-deep pending turn applied at the tick.
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   ST_READY  | no turn taken since last tick; a valid press is accepted at once
//   ST_LOCKED | a turn was taken; further turns wait for the next Speed_Clk
module ee354_project_input
    import ee354_project_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TICK_CYCLES     = 25000000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       BtnU,
    input  logic       BtnD,
    input  logic       BtnL,
    input  logic       BtnR,
    input  logic       q_Run,
    output logic [1:0] In_Dirn,
    output logic       SCEN,
    output logic       Speed_Clk
);

    localparam int            TW        = $clog2(TICK_CYCLES);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    logic          press_u, press_d, press_l, press_r;
    logic          cand_any, fresh_ok, tick_eff;
    logic [1:0]    cand;
    turn_state_t   state_q, state_d;
    logic [1:0]    dir_q, dir_d;
    logic          scen_q, scen_d;
    logic          speed_clk_q, speed_clk_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
`ifdef EE354_TURN_BUFFER_EN
    logic          pend_valid_q, pend_valid_d;
    logic [1:0]    pend_dir_q, pend_dir_d;
`endif

    function automatic logic turn_ok(input logic [1:0] c, input logic [1:0] cur);
        return (c != cur) && (c != opposite_dir(cur));
    endfunction

    ee354_project_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_u (
        .clk(Clk), .reset_n(Reset), .btn_raw(BtnU), .press(press_u));
    ee354_project_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_d (
        .clk(Clk), .reset_n(Reset), .btn_raw(BtnD), .press(press_d));
    ee354_project_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
        .clk(Clk), .reset_n(Reset), .btn_raw(BtnL), .press(press_l));
    ee354_project_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
        .clk(Clk), .reset_n(Reset), .btn_raw(BtnR), .press(press_r));

    // Fixed-priority arbitration U > D > L > R among same-cycle press events.
    always_comb begin
        cand_any = press_u | press_d | press_l | press_r;
        if (press_u)      cand = DIR_UP;
        else if (press_d) cand = DIR_DOWN;
        else if (press_l) cand = DIR_LEFT;
        else              cand = DIR_RIGHT;
    end

    assign fresh_ok = cand_any && turn_ok(cand, dir_q);
    // A tick landing right after an acceptance is absorbed so SCEN can never pulse twice in a row.
    assign tick_eff = speed_clk_q && !scen_q;

    // Tick generator: free-running 0..TICK_CYCLES-1 while running, parked at 0 otherwise.
    always_comb begin
        tick_cnt_d  = '0;
        speed_clk_d = 1'b0;
        if (q_Run) begin
            speed_clk_d = (tick_cnt_q == TICK_LAST);
            tick_cnt_d  = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
        end
    end

    // Turn FSM next state, direction update and SCEN strobe.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        scen_d  = 1'b0;
`ifdef EE354_TURN_BUFFER_EN
        pend_valid_d = pend_valid_q;
        pend_dir_d   = pend_dir_q;
`endif
        if (!q_Run) begin
            state_d = ST_READY;
`ifdef EE354_TURN_BUFFER_EN
            pend_valid_d = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_READY: begin
                    if (fresh_ok) begin
                        dir_d   = cand;
                        scen_d  = 1'b1;
                        state_d = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (tick_eff) begin
`ifdef EE354_TURN_BUFFER_EN
                        pend_valid_d = 1'b0;
`endif
                        if (fresh_ok) begin
                            dir_d  = cand;
                            scen_d = 1'b1;
                        end
`ifdef EE354_TURN_BUFFER_EN
                        else if (pend_valid_q && turn_ok(pend_dir_q, dir_q)) begin
                            dir_d  = pend_dir_q;
                            scen_d = 1'b1;
                        end
`endif
                        else begin
                            state_d = ST_READY;
                        end
                    end
`ifdef EE354_TURN_BUFFER_EN
                    else if (cand_any) begin
                        pend_valid_d = 1'b1;
                        pend_dir_d   = cand;
                    end
`endif
                end
                default: state_d = ST_READY;
            endcase
        end
    end

    // All state and outputs registered; synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q     <= ST_READY;
            dir_q       <= DIR_UP;
            scen_q      <= 1'b0;
            speed_clk_q <= 1'b0;
            tick_cnt_q  <= '0;
`ifdef EE354_TURN_BUFFER_EN
            pend_valid_q <= 1'b0;
            pend_dir_q   <= DIR_UP;
`endif
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            scen_q      <= scen_d;
            speed_clk_q <= speed_clk_d;
            tick_cnt_q  <= tick_cnt_d;
`ifdef EE354_TURN_BUFFER_EN
            pend_valid_q <= pend_valid_d;
            pend_dir_q   <= pend_dir_d;
`endif
        end
    end

    assign In_Dirn   = dir_q;
    assign SCEN      = scen_q;
    assign Speed_Clk = speed_clk_q;

endmodule

// File: tb/tb_ee354_project_input.sv
// Directed bench for ee354_project_input with DEBOUNCE_CYCLES=4, TICK_CYCLES=10.
module tb_ee354_project_input;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       BtnU, BtnD, BtnL, BtnR;
    logic       q_Run;
    logic [1:0] In_Dirn;
    logic       SCEN;
    logic       Speed_Clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int scen_cnt = 0;
    int last_scen = -1;
    int tick_cnt = 0;
    int last_tick = -1;

    ee354_project_input #(.DEBOUNCE_CYCLES(4), .TICK_CYCLES(10)) dut (
        .Clk(Clk), .Reset(Reset),
        .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR),
        .q_Run(q_Run), .In_Dirn(In_Dirn), .SCEN(SCEN), .Speed_Clk(Speed_Clk)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one clock; sample outputs 1 time unit after the rising edge.
    task automatic step();
        @(posedge Clk);
        #1;
        cyc++;
        if (SCEN === 1'b1) begin
            scen_cnt++;
            last_scen = cyc;
        end
        if (Speed_Clk === 1'b1) begin
            tick_cnt++;
            last_tick = cyc;
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic clr();
        cyc = 0; scen_cnt = 0; last_scen = -1; tick_cnt = 0; last_tick = -1;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        step();
        step();
        Reset = 1'b1;
        clr();
    endtask

    initial begin
        Reset = 1'b0; q_Run = 1'b0;
        BtnU = 1'b0; BtnD = 1'b0; BtnL = 1'b0; BtnR = 1'b0;
        step(); step(); step();
        check("rst_dirn", 32'(In_Dirn), 0);
        check("rst_scen", 32'(SCEN), 0);
        check("rst_tick", 32'(Speed_Clk), 0);

        // Idle with q_Run low: no ticks.
        Reset = 1'b1;
        clr();
        run_to(25);
        check("idle_no_tick", 32'(tick_cnt), 0);

        // Basic turn: q_Run and BtnL rise at cycle 0.
        clr();
        q_Run = 1'b1; BtnL = 1'b1;
        run_to(12);
        check("basic_scen_cnt", 32'(scen_cnt), 1);
        check("basic_scen_cyc", 32'(last_scen), 8);
        check("basic_dirn", 32'(In_Dirn), 2'b10);
        check("first_tick_cyc", 32'(last_tick), 10);

        // Glitch: U and R high for only 3 cycles.
        BtnL = 1'b0;
        clr();
        BtnU = 1'b1; BtnR = 1'b1;
        run_to(3);
        BtnU = 1'b0; BtnR = 1'b0;
        run_to(18);
        check("glitch_scen", 32'(scen_cnt), 0);
        check("glitch_dirn", 32'(In_Dirn), 2'b10);

        // Reverse rejection: D from UP, then L, then R after a tick.
        do_reset();
        BtnD = 1'b1;
        run_to(12);
        check("rev_d_scen", 32'(scen_cnt), 0);
        check("rev_d_dirn", 32'(In_Dirn), 2'b00);
        BtnD = 1'b0;
        run_to(13);
        BtnL = 1'b1;
        run_to(31);
        check("rev_l_scen_cyc", 32'(last_scen), 21);
        BtnR = 1'b1;
        run_to(42);
        check("rev_r_scen_cnt", 32'(scen_cnt), 1);
        check("rev_r_dirn", 32'(In_Dirn), 2'b10);
        BtnL = 1'b0; BtnR = 1'b0;

        // Priority: L+R together, then U+D together.
        do_reset();
        BtnL = 1'b1; BtnR = 1'b1;
        run_to(9);
        check("prio_lr_scen_cyc", 32'(last_scen), 8);
        check("prio_lr_dirn", 32'(In_Dirn), 2'b10);
        BtnL = 1'b0; BtnR = 1'b0;
        run_to(11);
        BtnU = 1'b1; BtnD = 1'b1;
        run_to(22);
        check("prio_ud_scen_cnt", 32'(scen_cnt), 2);
        check("prio_ud_scen_cyc", 32'(last_scen), 19);
        check("prio_ud_dirn", 32'(In_Dirn), 2'b00);
        BtnU = 1'b0; BtnD = 1'b0;

        // Lock/buffer: L accepted at 8, U press event at 9 while LOCKED.
        do_reset();
        BtnL = 1'b1;
        run_to(2);
        BtnU = 1'b1;
        run_to(14);
`ifdef EE354_TURN_BUFFER_EN
        check("lock_scen_cnt", 32'(scen_cnt), 2);
        check("lock_scen_cyc", 32'(last_scen), 11);
        check("lock_dirn", 32'(In_Dirn), 2'b00);
`else
        check("lock_scen_cnt", 32'(scen_cnt), 1);
        check("lock_scen_cyc", 32'(last_scen), 8);
        check("lock_dirn", 32'(In_Dirn), 2'b10);
`endif
        BtnL = 1'b0; BtnU = 1'b0;

        // Fresh press arriving exactly on the tick while LOCKED is accepted.
        do_reset();
        BtnL = 1'b1;
        run_to(3);
        BtnU = 1'b1;
        run_to(14);
        check("tickfresh_scen_cnt", 32'(scen_cnt), 2);
        check("tickfresh_scen_cyc", 32'(last_scen), 11);
        check("tickfresh_dirn", 32'(In_Dirn), 2'b00);
        BtnL = 1'b0; BtnU = 1'b0;

        // Reset while LOCKED (pending U captured at cycle 9 when buffered).
        do_reset();
        BtnL = 1'b1;
        run_to(2);
        BtnU = 1'b1;
        run_to(9);
        Reset = 1'b0;
        step();
        check("midrst_dirn", 32'(In_Dirn), 0);
        check("midrst_scen", 32'(SCEN), 0);
        check("midrst_tick", 32'(Speed_Clk), 0);
        BtnL = 1'b0; BtnU = 1'b0;
        step(); step();
        Reset = 1'b1;
        clr();
        run_to(20);
        check("postrst_scen", 32'(scen_cnt), 0);
        check("postrst_dirn", 32'(In_Dirn), 0);
        check("postrst_ticks", 32'(tick_cnt), 2);
        check("postrst_tick_cyc", 32'(last_tick), 20);

        // Run gating: q_Run low for 25 cycles with a valid press.
        q_Run = 1'b0;
        clr();
        BtnL = 1'b1;
        run_to(25);
        check("norun_ticks", 32'(tick_cnt), 0);
        check("norun_scen", 32'(scen_cnt), 0);
        check("norun_dirn", 32'(In_Dirn), 0);
        clr();
        q_Run = 1'b1; BtnL = 1'b0;
        run_to(12);
        check("rerun_tick_cyc", 32'(last_tick), 10);
        check("rerun_scen", 32'(scen_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
